// File: rtl/isqrt_iter_pkg.sv
// isqrt_iter_pkg: shared types, widths and cycle-count helper for the iterative isqrt engine
package isqrt_iter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int X_W   = 32;
  localparam int Y_W   = 16;
  localparam int REM_W = 17;
  localparam int ACC_W = 18;
  function automatic int n_cycles(input int iter_per_clk);
    return 16 / iter_per_clk;
  endfunction
endpackage

// File: rtl/isqrt_iter_step.sv
// isqrt_iter_step: one restoring square-root iteration consuming the next radicand bit pair
module isqrt_iter_step
  import isqrt_iter_pkg::*;
(
  input  logic [ACC_W-1:0] i_rem,
  input  logic [Y_W-1:0]   i_root,
  input  logic [1:0]       i_bits,
  output logic [ACC_W-1:0] o_rem,
  output logic [Y_W-1:0]   o_root
);
  logic [ACC_W-1:0] w_r;
  logic [ACC_W-1:0] w_t;
  logic             w_ge;
  logic             w_unused;
  assign w_r      = {i_rem[Y_W-1:0], i_bits};
  assign w_t      = {i_root, 2'b01};
  assign w_ge     = w_r >= w_t;
  assign o_rem    = w_ge ? w_r - w_t : w_r;
  assign o_root   = {i_root[Y_W-2:0], w_ge};
  assign w_unused = ^i_rem[ACC_W-1:Y_W];
endmodule

// File: rtl/isqrt_iter.sv
// isqrt_iter: iterative 32-bit floor(sqrt(x)), ITER_PER_CLK root bits per clock; ISQRT_ITER_REM_EN adds the rem port
module isqrt_iter
  import isqrt_iter_pkg::*;
#(
  parameter int ITER_PER_CLK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_vld,
  input  logic [X_W-1:0]   x,
  output logic             busy,
  output logic             y_vld,
  output logic [Y_W-1:0]   y
`ifdef ISQRT_ITER_REM_EN
  ,
  output logic [REM_W-1:0] rem
`endif
);
  localparam int N = n_cycles(ITER_PER_CLK);

  if (ITER_PER_CLK != 1 && ITER_PER_CLK != 2 && ITER_PER_CLK != 4 &&
      ITER_PER_CLK != 8 && ITER_PER_CLK != 16) begin : g_bad_ipc
    $error("isqrt_iter: ITER_PER_CLK must be 1, 2, 4, 8 or 16");
  end

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [X_W-1:0]   r_data;
  logic [ACC_W-1:0] r_rem;
  logic [Y_W-1:0]   r_root;
  logic [Y_W-1:0]   r_y;
`ifdef ISQRT_ITER_REM_EN
  logic [REM_W-1:0] r_rem_out;
`endif

  logic [ACC_W-1:0] w_rem  [ITER_PER_CLK+1];
  logic [Y_W-1:0]   w_root [ITER_PER_CLK+1];

  assign w_rem[0]  = r_rem;
  assign w_root[0] = r_root;

  for (genvar i = 0; i < ITER_PER_CLK; i++) begin : g_step
    isqrt_iter_step u_step (
      .i_rem  (w_rem[i]),
      .i_root (w_root[i]),
      .i_bits (r_data[X_W-1-2*i -: 2]),
      .o_rem  (w_rem[i+1]),
      .o_root (w_root[i+1])
    );
  end

  // FSM: accept in IDLE/DONE, iterate N cycles in BUSY, capture result on the BUSY->DONE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_data    <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_y       <= '0;
`ifdef ISQRT_ITER_REM_EN
      r_rem_out <= '0;
`endif
    end else begin
      case (r_state)
        BUSY: begin
          r_data <= r_data << (2 * ITER_PER_CLK);
          r_rem  <= w_rem[ITER_PER_CLK];
          r_root <= w_root[ITER_PER_CLK];
          r_cnt  <= r_cnt - 4'd1;
          if (r_cnt == '0) begin
            r_state   <= DONE;
            r_y       <= w_root[ITER_PER_CLK];
`ifdef ISQRT_ITER_REM_EN
            r_rem_out <= w_rem[ITER_PER_CLK][REM_W-1:0];
`endif
          end
        end
        default: begin
          r_state <= x_vld ? BUSY : IDLE;
          if (x_vld) begin
            r_data <= x;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= 4'(N - 1);
          end
        end
      endcase
    end
  end

  assign busy  = r_state == BUSY;
  assign y_vld = r_state == DONE;
  assign y     = r_y;
`ifdef ISQRT_ITER_REM_EN
  assign rem   = r_rem_out;
`endif
endmodule
